// File: rtl/spi_datagram_seq.sv
`default_nettype none
// ============================================================================
// Module   : spi_datagram_seq
// Purpose  : Queues register read/write requests and sequences them as 40-bit
//            SPI datagrams with fixed transfer and gap timing.
// Options  : SEQ_READ_REPEAT_EN - each read is transferred twice; only the
//            second capture produces a response.
// Revision : 1.0 - initial release
// ============================================================================
module spi_datagram_seq #(
    parameter int XFER_CYCLES = 250,
    parameter int GAP_CYCLES  = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_write_in,
    input  logic [6:0]  req_addr_in,
    input  logic [31:0] req_data_in,
    output logic [39:0] spi_data_out,
    output logic        spi_send_enable_out,
    input  logic [39:0] spi_data_in,
    output logic        resp_valid_out,
    output logic [7:0]  resp_status_out,
    output logic [31:0] resp_data_out,
    output logic        busy_out
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] c_XFER_LAST = CNT_W'(XFER_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W:0]   c_FULL      = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [CNT_W-1:0]   r_cnt_q, w_cnt_d;
    logic [39:0]        r_data_q, w_data_d;
    logic               r_rpt_q, w_rpt_d;
    logic               r_resp_valid_q, w_resp_valid_d;
    logic [7:0]         r_status_q, w_status_d;
    logic [31:0]        r_rdata_q, w_rdata_d;
    logic [PTR_W-1:0]   r_wr_ptr_q, w_wr_ptr_d;
    logic [PTR_W-1:0]   r_rd_ptr_q, w_rd_ptr_d;
    logic [PTR_W:0]     r_count_q, w_count_d;
    logic [39:0]        r_mem_q [FIFO_DEPTH];

    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic [39:0]        w_push_dg;
    logic [39:0]        w_head_dg;

    // ------------------------------------------------------------------
    // Request FIFO; ready reflects only the registered occupancy
    // ------------------------------------------------------------------
    assign w_empty       = (r_count_q == '0);
    assign req_ready_out = (r_count_q != c_FULL);
    assign w_push        = req_valid_in & req_ready_out;
    assign w_pop         = (r_state_q == S_IDLE) & ~w_empty;
    assign w_push_dg     = {req_write_in, req_addr_in, (req_write_in ? req_data_in : 32'h0)};
    assign w_head_dg     = r_mem_q[r_rd_ptr_q];

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + (PTR_W + 1)'(1);
            2'b01:   w_count_d = r_count_q - (PTR_W + 1)'(1);
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr_q] <= w_push_dg;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d      = r_state_q;
        w_cnt_d        = r_cnt_q;
        w_data_d       = r_data_q;
        w_rpt_d        = r_rpt_q;
        w_resp_valid_d = 1'b0;
        w_status_d     = r_status_q;
        w_rdata_d      = r_rdata_q;

        case (r_state_q)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_d = S_XFER;
                    w_cnt_d   = '0;
                    w_data_d  = w_head_dg;
`ifdef SEQ_READ_REPEAT_EN
                    w_rpt_d   = ~w_head_dg[39];
`else
                    w_rpt_d   = 1'b0;
`endif
                end
            end
            S_XFER: begin
                if (r_cnt_q == c_XFER_LAST) begin
                    w_state_d = S_GAP;
                    w_cnt_d   = '0;
                    // The first pass of a repeated read is not reported
                    if (!r_rpt_q) begin
                        w_resp_valid_d = 1'b1;
                        w_status_d     = spi_data_in[39:32];
                        w_rdata_d      = spi_data_in[31:0];
                    end
                end else begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (r_cnt_q == c_GAP_LAST) begin
                    w_cnt_d = '0;
                    if (r_rpt_q) begin
                        w_state_d = S_XFER;
                        w_rpt_d   = 1'b0;
                    end else begin
                        w_state_d = S_IDLE;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_cnt_d   = '0;
                w_rpt_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state_q      <= S_IDLE;
            r_cnt_q        <= '0;
            r_data_q       <= '0;
            r_rpt_q        <= 1'b0;
            r_resp_valid_q <= 1'b0;
            r_status_q     <= '0;
            r_rdata_q      <= '0;
            r_wr_ptr_q     <= '0;
            r_rd_ptr_q     <= '0;
            r_count_q      <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_data_q       <= w_data_d;
            r_rpt_q        <= w_rpt_d;
            r_resp_valid_q <= w_resp_valid_d;
            r_status_q     <= w_status_d;
            r_rdata_q      <= w_rdata_d;
            r_wr_ptr_q     <= w_wr_ptr_d;
            r_rd_ptr_q     <= w_rd_ptr_d;
            r_count_q      <= w_count_d;
        end
    end

    // Decoded from the state flop so an asynchronous reset drops it at once
    assign spi_send_enable_out = (r_state_q == S_XFER);
    assign spi_data_out        = r_data_q;
    assign resp_valid_out      = r_resp_valid_q;
    assign resp_status_out     = r_status_q;
    assign resp_data_out       = r_rdata_q;
    assign busy_out            = ~w_empty | (r_state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_datagram_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_datagram_seq
// Purpose  : Scoreboard bench for spi_datagram_seq (XFER=10, GAP=2, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_datagram_seq;

    localparam int XC = 10;
    localparam int GC = 2;
    localparam int FD = 4;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_write_in;
    logic [6:0]  req_addr_in;
    logic [31:0] req_data_in;
    logic [39:0] spi_data_out;
    logic        spi_send_enable_out;
    logic [39:0] spi_data_in;
    logic        resp_valid_out;
    logic [7:0]  resp_status_out;
    logic [31:0] resp_data_out;
    logic        busy_out;

    spi_datagram_seq #(
        .XFER_CYCLES (XC),
        .GAP_CYCLES  (GC),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .req_valid_in        (req_valid_in),
        .req_ready_out       (req_ready_out),
        .req_write_in        (req_write_in),
        .req_addr_in         (req_addr_in),
        .req_data_in         (req_data_in),
        .spi_data_out        (spi_data_out),
        .spi_send_enable_out (spi_send_enable_out),
        .spi_data_in         (spi_data_in),
        .resp_valid_out      (resp_valid_out),
        .resp_status_out     (resp_status_out),
        .resp_data_out       (resp_data_out),
        .busy_out            (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    int rdy_low = 0;

    logic [39:0] exp_dg_q[$];
    logic [39:0] miso_q[$];
    logic [39:0] exp_resp_q[$];
    int          rise_cyc[$];
    int          fall_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: datagrams, transfer length and responses against the queues
    initial begin : monitor
        logic        prev_en;
        int          hi_len;
        logic [39:0] cur_dg;
        logic [39:0] e;
        prev_en = 1'b0;
        hi_len  = 0;
        cur_dg  = '0;
        forever begin
            @(negedge clk_in);
            if (!rst_n_in) begin
                prev_en = 1'b0;
                hi_len  = 0;
            end else begin
                if (spi_send_enable_out && !prev_en) begin
                    rise_cyc.push_back(cyc);
                    hi_len = 0;
                    if (exp_dg_q.size() == 0) begin
                        chk("unexpected_xfer", 64'd1, 64'd0);
                    end else begin
                        cur_dg = exp_dg_q.pop_front();
                        chk("datagram", spi_data_out, cur_dg);
                    end
                end
                if (spi_send_enable_out) begin
                    hi_len++;
                    chk("data_stable", spi_data_out, cur_dg);
                end
                if (!spi_send_enable_out && prev_en) begin
                    fall_cyc.push_back(cyc);
                    chk("xfer_len", hi_len, XC);
                end
                if (resp_valid_out) begin
                    chk("resp_first_gap_cycle", {63'd0, (!spi_send_enable_out && prev_en)}, 64'd1);
                    if (exp_resp_q.size() == 0) begin
                        chk("unexpected_resp", 64'd1, 64'd0);
                    end else begin
                        e = exp_resp_q.pop_front();
                        chk("resp_status", resp_status_out, e[39:32]);
                        chk("resp_data", resp_data_out, e[31:0]);
                    end
                end
                prev_en = spi_send_enable_out;
            end
        end
    end

    // Slave model: present the next captured word when a transfer starts
    initial begin : responder
        logic p;
        p = 1'b0;
        spi_data_in = '0;
        forever begin
            @(posedge clk_in);
            #1;
            if (spi_send_enable_out && !p && miso_q.size() > 0) begin
                spi_data_in = miso_q.pop_front();
            end
            p = spi_send_enable_out;
        end
    end

    initial begin : ready_watch
        forever begin
            @(negedge clk_in);
            if (rst_n_in && !req_ready_out) rdy_low++;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic w, input logic [6:0] a, input logic [31:0] d,
                         input logic [39:0] miso, output int acc);
        logic [39:0] dg;
        int n;
        dg = {w, a, (w ? d : 32'h0)};
        @(negedge clk_in);
        req_valid_in = 1'b1;
        req_write_in = w;
        req_addr_in  = a;
        req_data_in  = d;
        n = 0;
        while (!req_ready_out && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 64'd0, 64'd1);
        stalls += n;
        acc = cyc + 1;
        exp_dg_q.push_back(dg);
`ifdef SEQ_READ_REPEAT_EN
        if (!w) begin
            exp_dg_q.push_back(dg);
            miso_q.push_back(~miso);
        end
`endif
        miso_q.push_back(miso);
        exp_resp_q.push_back(miso);
        @(posedge clk_in);
        #1;
        req_valid_in = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        @(negedge clk_in);
        while (busy_out && n < max) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= max) chk("idle_timeout", 64'd0, 64'd1);
        repeat (3) @(negedge clk_in);
    endtask

    initial begin : stimulus
        int acc;
        int n;
        int rise_before;

        rst_n_in     = 1'b0;
        req_valid_in = 1'b0;
        req_write_in = 1'b0;
        req_addr_in  = '0;
        req_data_in  = '0;
        repeat (3) @(negedge clk_in);
        chk("rst_en", spi_send_enable_out, 0);
        chk("rst_dout", spi_data_out, 0);
        chk("rst_resp_valid", resp_valid_out, 0);
        chk("rst_status", resp_status_out, 0);
        chk("rst_rdata", resp_data_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_ready", req_ready_out, 1);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // Single write with latency and captured response
        issue(1'b1, 7'h6C, 32'h000100C3, 40'h0912345678, acc);
        chk("busy_after_accept", busy_out, 1);
        wait_idle(200);
        chk("latency", rise_cyc[0] + 1, acc + 2);
        chk("status_hold", resp_status_out, 8'h09);
        chk("rdata_hold", resp_data_out, 32'h12345678);

        // Read: data input ignored, optional repeat
        issue(1'b0, 7'h6F, 32'hDEADBEEF, 40'hA500001234, acc);
        wait_idle(200);
`ifdef SEQ_READ_REPEAT_EN
        chk("read_xfer_count", rise_cyc.size(), 3);
        chk("read_repeat_gap", rise_cyc[2] - fall_cyc[1], GC);
`else
        chk("read_xfer_count", rise_cyc.size(), 2);
`endif

        // Five back-to-back writes into a 4-deep FIFO
        stalls  = 0;
        rdy_low = 0;
        issue(1'b1, 7'h01, 32'h11111111, 40'h0100000001, acc);
        issue(1'b1, 7'h02, 32'h22222222, 40'h0200000002, acc);
        issue(1'b1, 7'h03, 32'h33333333, 40'h0300000003, acc);
        issue(1'b1, 7'h04, 32'h44444444, 40'h0400000004, acc);
        issue(1'b1, 7'h05, 32'h55555555, 40'h0500000005, acc);
        wait_idle(500);
        chk("b2b_stalls", stalls, 0);
        chk("ready_low_cycles", rdy_low, 10);
        chk("dg_queue_drained", exp_dg_q.size(), 0);
        chk("resp_queue_drained", exp_resp_q.size(), 0);

        // Reset during the fifth cycle of a transfer with two queued
        issue(1'b1, 7'h10, 32'hA0A0A0A0, 40'h1000000010, acc);
        issue(1'b1, 7'h11, 32'hA1A1A1A1, 40'h1100000011, acc);
        issue(1'b1, 7'h12, 32'hA2A2A2A2, 40'h1200000012, acc);
        n = 0;
        while (!spi_send_enable_out && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 50) chk("xfer_start_timeout", 64'd0, 64'd1);
        repeat (3) @(negedge clk_in);
        @(posedge clk_in);
        #2;
        rst_n_in = 1'b0;
        exp_dg_q.delete();
        miso_q.delete();
        exp_resp_q.delete();
        rise_before = rise_cyc.size();
        #1;
        chk("rst_async_en", spi_send_enable_out, 0);
        chk("rst_async_busy", busy_out, 0);
        chk("rst_async_ready", req_ready_out, 1);
        chk("rst_async_dout", spi_data_out, 0);
        chk("rst_async_status", resp_status_out, 0);
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (40) @(negedge clk_in);
        chk("no_xfer_after_reset", rise_cyc.size(), rise_before);
        chk("busy_after_reset", busy_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_datagram_seq.md
SPI_DATAGRAM_SEQ -- requirements
Module: spi_datagram_seq

Interface
REQ-001 Parameter XFER_CYCLES, default 250: number of clk_in cycles spi_send_enable_out is held high per datagram; must be >= 1.
REQ-002 Parameter GAP_CYCLES, default 8: idle cycles with spi_send_enable_out low between datagrams; must be >= 1.
REQ-003 Parameter FIFO_DEPTH, default 4: request FIFO entries; must be a power of 2 and >= 2.
REQ-004 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 req_valid_in  input  1  request present.
REQ-007 req_ready_out  output  1  FIFO can accept a request.
REQ-008 req_write_in  input  1  1 = register write, 0 = register read.
REQ-009 req_addr_in  input  7  register address.
REQ-010 req_data_in  input  32  write data; ignored for reads.
REQ-011 spi_data_out  output  40  datagram to the SPI master.
REQ-012 spi_send_enable_out  output  1  transfer enable to the SPI master.
REQ-013 spi_data_in  input  40  word shifted in by the SPI master.
REQ-014 resp_valid_out  output  1  one-cycle response strobe.
REQ-015 resp_status_out  output  8  returned status byte.
REQ-016 resp_data_out  output  32  returned register data.
REQ-017 busy_out  output  1  FIFO non-empty or FSM not IDLE.

Function
REQ-018 A request is accepted on any rising edge with req_valid_in and req_ready_out both high; req_ready_out = FIFO not full and does not depend on a same-cycle pop.
REQ-019 Datagram format: bit 39 = req_write_in, bits 38:32 = req_addr_in, bits 31:0 = req_data_in (forced to 0 for reads).
REQ-020 FSM states: IDLE, XFER, GAP.
REQ-021 IDLE: if FIFO non-empty, pop head, register it onto spi_data_out, go to XFER; otherwise stay.
REQ-022 XFER: spi_send_enable_out high for exactly XFER_CYCLES consecutive cycles, starting the cycle after the pop; spi_data_out held stable throughout.
REQ-023 At the XFER->GAP edge, spi_data_in is captured: status = bits 39:32, data = bits 31:0.
REQ-024 resp_valid_out pulses for one cycle, the first GAP cycle, only after the final transfer of a request; resp_status_out/resp_data_out hold their value until the next capture.
REQ-025 GAP: spi_send_enable_out low for exactly GAP_CYCLES cycles, then IDLE, or XFER again per REQ-031.
REQ-026 Request latency, FIFO empty and IDLE: accept at edge t, pop at t+1, spi_send_enable_out high from t+2 through t+1+XFER_CYCLES.
REQ-027 Requests are issued strictly in acceptance order; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-028 Push and pop in the same cycle when non-full: both occur, occupancy unchanged.

Reset
REQ-029 While rst_n_in low: FSM = IDLE, FIFO empty, counters 0, spi_send_enable_out 0, spi_data_out 0, resp_valid_out 0, resp_status_out 0, resp_data_out 0, busy_out 0, req_ready_out 1.
REQ-030 Reset asserted mid-transfer drops spi_send_enable_out immediately (asynchronously); the in-flight and queued requests are discarded with no response.

Configuration
REQ-031 Macro SEQ_READ_REPEAT_EN defined: each read request is transferred twice with identical datagrams separated by GAP_CYCLES, and only the second capture produces resp_valid_out; undefined: every request is a single transfer producing one response.

Verification
REQ-032 XFER_CYCLES=10, GAP_CYCLES=2: write addr 0x6C data 0x000100C3 -> spi_data_out = 0xEC000100C3, send_enable high exactly 10 cycles starting 2 cycles after accept, one resp_valid pulse.
REQ-033 spi_data_in = 0x0912345678 at end of XFER -> resp_status_out = 0x09, resp_data_out = 0x12345678 on the resp_valid_out cycle.
REQ-034 Read addr 0x6F with SEQ_READ_REPEAT_EN -> two 10-cycle transfers of 0x6F00000000 with a 2-cycle gap, one resp_valid after the second; without the macro -> one transfer, one response.
REQ-035 Push 5 requests back-to-back, FIFO_DEPTH=4, while IDLE -> all 5 accepted (pop frees a slot), req_ready_out low for exactly the cycles the FIFO is full, datagrams emitted in order.
REQ-036 Assert rst_n_in low at cycle 5 of a transfer with 2 requests queued -> send_enable falls the same cycle, no resp_valid, busy_out 0, no further transfers after release.
